// File: rtl/dma_wr_engine.sv
// Single-clock DMA write engine: buffers the bdo stream in a show-ahead FIFO and drains it to the master-write port.
// Optional DMA_WR_BYTE_EN_EN adds a byte-enable output; without it, masked-off bytes are zeroed in the write data.
module dma_wr_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 32,
    parameter int DEPTH  = 8,
    parameter int FAIL_W = 16,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              iClk,
    input  logic              iRstn,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [LEN_W-1:0]  length_i,
    input  logic [ADDR_W-1:0] out_gap_i,
    input  logic              auth_en_i,
    input  logic              bdo_vld_i,
    input  logic [DATA_W-1:0] bdo_i,
    input  logic [BE_W-1:0]   bdo_vld_byte_i,
    input  logic              bdo_last_i,
    output logic              bdo_rdy_o,
    input  logic              auth_vld_i,
    input  logic              tag_match_i,
    output logic [ADDR_W-1:0] oAddress_Master_Write,
    output logic [DATA_W-1:0] oData_Master_Write,
`ifdef DMA_WR_BYTE_EN_EN
    output logic [BE_W-1:0]   oByteEnable_Master_Write,
`endif
    output logic              oWrite_Master_Write,
    input  logic              iWait_Master_Write,
    output logic              busy_o,
    output logic [FAIL_W-1:0] tag_fail_nums_o,
    output logic [ADDR_W-1:0] end_addr_write_o,
    output logic              done_trigger_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 1 + BE_W + DATA_W;

    typedef enum logic [1:0] {IDLE, RUN, WAIT_AUTH, DONE} state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0]  addr, gap;
    logic [LEN_W-1:0]   length, pushed, written;
    logic               auth_en, auth_seen;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W:0]     wr_ptr, rd_ptr;
    logic               full, empty, push, pop, busy;
    logic               head_last;
    logic [BE_W-1:0]    head_mask;
    logic [DATA_W-1:0]  head_data;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign {head_last, head_mask, head_data} = mem[rd_ptr[PTR_W-1:0]];

    assign busy                  = (state == RUN) || (state == WAIT_AUTH);
    assign busy_o                = busy;
    assign done_trigger_o        = (state == DONE);
    assign bdo_rdy_o             = (state == RUN) && !full && (pushed < length);
    assign oWrite_Master_Write   = (state == RUN) && !empty;
    assign push                  = bdo_vld_i && bdo_rdy_o;
    assign pop                   = oWrite_Master_Write && !iWait_Master_Write;
    assign oAddress_Master_Write = addr;

`ifdef DMA_WR_BYTE_EN_EN
    assign oByteEnable_Master_Write = oWrite_Master_Write ? head_mask : '0;
    assign oData_Master_Write       = oWrite_Master_Write ? head_data : '0;
`else
    logic [DATA_W-1:0] masked_data;

    always_comb begin
        masked_data = '0;
        for (int b = 0; b < BE_W; b++) begin
            if (head_mask[b]) masked_data[b*8 +: 8] = head_data[b*8 +: 8];
        end
    end

    assign oData_Master_Write = oWrite_Master_Write ? masked_data : '0;
`endif

    always_ff @(posedge iClk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= {bdo_last_i, bdo_vld_byte_i, bdo_i};
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start_i) state_next = RUN;
            RUN:       if (written == length) state_next = auth_en ? WAIT_AUTH : DONE;
            WAIT_AUTH: if (auth_seen || auth_vld_i) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            addr             <= '0;
            gap              <= '0;
            length           <= '0;
            pushed           <= '0;
            written          <= '0;
            auth_en          <= 1'b0;
            auth_seen        <= 1'b0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            tag_fail_nums_o  <= '0;
            end_addr_write_o <= '0;
        end else begin
            if (state == IDLE && start_i) begin
                addr      <= d_addr_i;
                gap       <= out_gap_i;
                length    <= length_i;
                auth_en   <= auth_en_i;
                pushed    <= '0;
                written   <= '0;
                auth_seen <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
                pushed <= pushed + LEN_W'(1);
            end
            // A segment-last word also skips the output gap before the next word.
            if (pop) begin
                rd_ptr  <= rd_ptr + (PTR_W+1)'(1);
                written <= written + LEN_W'(1);
                addr    <= addr + ADDR_W'(BE_W) + (head_last ? gap : '0);
            end
            // Only the first auth result of a job counts; it may arrive before the writes finish.
            if (busy && auth_vld_i && !auth_seen) begin
                auth_seen <= 1'b1;
                if (!tag_match_i && (tag_fail_nums_o != '1))
                    tag_fail_nums_o <= tag_fail_nums_o + FAIL_W'(1);
            end
            if (state_next == DONE) end_addr_write_o <= addr;
        end
    end

endmodule

// File: tb/tb_dma_wr_engine.sv
// Directed self-checking bench for dma_wr_engine; a narrow fail counter makes saturation reachable.
module tb_dma_wr_engine;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 32;
    localparam int DEPTH  = 8;
    localparam int FAIL_W = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] d_addr = '0, length = '0, out_gap = '0;
    logic        auth_en = 1'b0;
    logic        bdo_vld = 1'b0;
    logic [31:0] bdo = '0;
    logic [3:0]  bdo_be = '0;
    logic        bdo_last = 1'b0;
    logic        bdo_rdy;
    logic        auth_vld = 1'b0, tag_match = 1'b0;
    logic [31:0] wr_addr, wr_data;
    logic        wr_req;
    logic        wr_wait = 1'b0;
    logic        busy;
    logic [1:0]  tag_fail;
    logic [31:0] end_addr;
    logic        done;
`ifdef DMA_WR_BYTE_EN_EN
    logic [3:0]  wr_be;
`endif

    int compared = 0, mismatched = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0, start_cyc = 0, exp_done = 0;
    logic [31:0] wr_addr_q[$], wr_data_q[$];
    logic [31:0] ea[$], ed[$];

    dma_wr_engine #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DEPTH(DEPTH), .FAIL_W(FAIL_W)
    ) dut (
        .iClk(clk),
        .iRstn(rst_n),
        .start_i(start),
        .d_addr_i(d_addr),
        .length_i(length),
        .out_gap_i(out_gap),
        .auth_en_i(auth_en),
        .bdo_vld_i(bdo_vld),
        .bdo_i(bdo),
        .bdo_vld_byte_i(bdo_be),
        .bdo_last_i(bdo_last),
        .bdo_rdy_o(bdo_rdy),
        .auth_vld_i(auth_vld),
        .tag_match_i(tag_match),
        .oAddress_Master_Write(wr_addr),
        .oData_Master_Write(wr_data),
`ifdef DMA_WR_BYTE_EN_EN
        .oByteEnable_Master_Write(wr_be),
`endif
        .oWrite_Master_Write(wr_req),
        .iWait_Master_Write(wr_wait),
        .busy_o(busy),
        .tag_fail_nums_o(tag_fail),
        .end_addr_write_o(end_addr),
        .done_trigger_o(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Inputs change just after the rising edge, so what the negedge sees is what the next edge accepts.
    always @(negedge clk) begin
        if (wr_req && !wr_wait) begin
            wr_addr_q.push_back(wr_addr);
            wr_data_q.push_back(wr_data);
            last_wr_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [31:0] a, input logic [31:0] len,
                             input logic [31:0] g, input logic aen);
        @(posedge clk); #1;
        d_addr = a; length = len; out_gap = g; auth_en = aen; start = 1'b1;
        start_cyc = cyc;
        wr_addr_q.delete();
        wr_data_q.delete();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] data, input logic [3:0] be, input logic last);
        int n = 0;
        logic acc = 1'b0;
        bdo_vld = 1'b1; bdo = data; bdo_be = be; bdo_last = last;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bdo_rdy;
            @(posedge clk); #1;
            n++;
        end
        bdo_vld = 1'b0; bdo_last = 1'b0;
        check_output("push_accept", 64'(acc), 64'd1);
    endtask

    task automatic pulse_auth(input logic match);
        auth_vld = 1'b1; tag_match = match;
        @(posedge clk); #1;
        auth_vld = 1'b0; tag_match = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        exp_done++;
        while (done_cnt < exp_done && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check_output({tag, "_done_count"}, 64'(done_cnt), 64'(exp_done));
    endtask

    task automatic compare_writes(input string tag);
        check_output({tag, "_write_count"}, 64'(wr_addr_q.size()), 64'(ea.size()));
        for (int i = 0; i < ea.size(); i++) begin
            check_output($sformatf("%s_addr%0d", tag, i),
                         (i < wr_addr_q.size()) ? 64'(wr_addr_q[i]) : 64'hx, 64'(ea[i]));
            check_output($sformatf("%s_data%0d", tag, i),
                         (i < wr_data_q.size()) ? 64'(wr_data_q[i]) : 64'hx, 64'(ed[i]));
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check_output("rst_write", 64'(wr_req), 64'd0);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_rdy", 64'(bdo_rdy), 64'd0);
        check_output("rst_done", 64'(done), 64'd0);
        check_output("rst_tag_fail", 64'(tag_fail), 64'd0);
        check_output("rst_end_addr", 64'(end_addr), 64'd0);
        check_output("rst_data", 64'(wr_data), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic four-word job
        start_job(32'h1000, 32'd4, 32'h0, 1'b0);
        check_output("t1_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) push_word(32'h1111_0000 + i, 4'hF, 1'b0);
        wait_done("t1");
        ea = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        ed = '{32'h1111_0000, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003};
        compare_writes("t1");
        // Last accept, one RUN cycle seeing written == length, then DONE.
        check_output("t1_done_latency", 64'(done_cyc - last_wr_cyc), 64'd2);
        check_output("t1_end_addr", 64'(end_addr), 64'h1010);
        check_output("t1_busy_after", 64'(busy), 64'd0);

        // Back-pressure: fill the FIFO, then stall the second write for three cycles
        @(posedge clk); #1;
        wr_wait = 1'b1;
        start_job(32'h3000, 32'd12, 32'h0, 1'b0);
        fork
            begin
                for (int i = 0; i < 12; i++) push_word(32'hC0DE_0000 + i, 4'hF, 1'b0);
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                @(negedge clk);
                check_output("t2_full_rdy", 64'(bdo_rdy), 64'd0);
                check_output("t2_hold_addr0", 64'(wr_addr), 64'h3000);
                check_output("t2_hold_data0", 64'(wr_data), 64'hC0DE_0000);
                @(posedge clk); #1;
                wr_wait = 1'b0;
                @(posedge clk); #1;
                wr_wait = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check_output($sformatf("t2_stall_addr%0d", k), 64'(wr_addr), 64'h3004);
                    check_output($sformatf("t2_stall_data%0d", k), 64'(wr_data), 64'hC0DE_0001);
                    @(posedge clk); #1;
                end
                wr_wait = 1'b0;
            end
        join
        wait_done("t2");
        ea.delete(); ed.delete();
        for (int i = 0; i < 12; i++) begin
            ea.push_back(32'h3000 + 4 * i);
            ed.push_back(32'hC0DE_0000 + i);
        end
        compare_writes("t2");
        check_output("t2_end_addr", 64'(end_addr), 64'h3030);

        // Segment gap after word 2, plus a partial byte mask on word 3
        start_job(32'h2000, 32'd4, 32'h10, 1'b0);
        push_word(32'h2222_0000, 4'hF, 1'b0);
        push_word(32'h2222_0001, 4'hF, 1'b1);
        push_word(32'hAABB_CCDD, 4'b0101, 1'b0);
        push_word(32'h2222_0003, 4'hF, 1'b0);
        wait_done("t3");
        ea = '{32'h2000, 32'h2004, 32'h2018, 32'h201C};
`ifdef DMA_WR_BYTE_EN_EN
        ed = '{32'h2222_0000, 32'h2222_0001, 32'hAABB_CCDD, 32'h2222_0003};
`else
        ed = '{32'h2222_0000, 32'h2222_0001, 32'h00BB_00DD, 32'h2222_0003};
`endif
        compare_writes("t3");
        check_output("t3_end_addr", 64'(end_addr), 64'h2020);

        // Early failing auth (sent twice) while writes are stalled
        @(posedge clk); #1;
        wr_wait = 1'b1;
        start_job(32'h4000, 32'd4, 32'h0, 1'b1);
        pulse_auth(1'b0);
        pulse_auth(1'b0);
        check_output("t4_tag_fail_once", 64'(tag_fail), 64'd1);
        for (int i = 0; i < 4; i++) push_word(32'h4444_0000 + i, 4'hF, 1'b0);
        check_output("t4_no_early_done", 64'(done_cnt), 64'(exp_done));
        check_output("t4_busy", 64'(busy), 64'd1);
        wr_wait = 1'b0;
        wait_done("t4");
        ea = '{32'h4000, 32'h4004, 32'h4008, 32'h400C};
        ed = '{32'h4444_0000, 32'h4444_0001, 32'h4444_0002, 32'h4444_0003};
        compare_writes("t4");
        // RUN sees written == length, WAIT_AUTH completes on the stored flag, then DONE.
        check_output("t4_done_latency", 64'(done_cyc - last_wr_cyc), 64'd3);
        check_output("t4_tag_fail_after", 64'(tag_fail), 64'd1);

        // WAIT_AUTH holds until a live passing auth arrives
        start_job(32'h7000, 32'd0, 32'h0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check_output("t5_waiting_busy", 64'(busy), 64'd1);
        check_output("t5_waiting_no_done", 64'(done_cnt), 64'(exp_done));
        pulse_auth(1'b1);
        wait_done("t5");
        check_output("t5_tag_fail", 64'(tag_fail), 64'd1);
        check_output("t5_no_writes", 64'(wr_addr_q.size()), 64'd0);
        check_output("t5_end_addr", 64'(end_addr), 64'h7000);

        // Saturation of the 2-bit fail counter
        for (int j = 0; j < 3; j++) begin
            start_job(32'h0, 32'd0, 32'h0, 1'b1);
            pulse_auth(1'b0);
            wait_done("t6");
            check_output($sformatf("t6_tag_fail_job%0d", j), 64'(tag_fail), (j == 0) ? 64'd2 : 64'd3);
        end

        // Zero-length job without auth
        start_job(32'h8000, 32'd0, 32'h0, 1'b0);
        wait_done("t7");
        check_output("t7_done_latency", 64'(done_cyc - start_cyc), 64'd2);
        check_output("t7_no_writes", 64'(wr_addr_q.size()), 64'd0);
        check_output("t7_end_addr", 64'(end_addr), 64'h8000);

        // Reset mid-job with three words queued behind a stalled write
        @(posedge clk); #1;
        wr_wait = 1'b1;
        start_job(32'h5000, 32'd5, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) push_word(32'h5555_0000 + i, 4'hF, 1'b0);
        check_output("t8_write_pending", 64'(wr_req), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check_output("t8_rst_write", 64'(wr_req), 64'd0);
        check_output("t8_rst_busy", 64'(busy), 64'd0);
        check_output("t8_rst_rdy", 64'(bdo_rdy), 64'd0);
        check_output("t8_rst_tag_fail", 64'(tag_fail), 64'd0);
        check_output("t8_rst_addr", 64'(wr_addr), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wr_wait = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("t8_no_done", 64'(done_cnt), 64'(exp_done));
        start_job(32'h6000, 32'd1, 32'h0, 1'b0);
        push_word(32'h600D_F00D, 4'hF, 1'b1);
        wait_done("t8");
        ea = '{32'h6000};
        ed = '{32'h600D_F00D};
        compare_writes("t8");
        check_output("t8_end_addr", 64'(end_addr), 64'h6004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
